// File: rtl/vga_line_fetch_arbiter_if.sv
// Signal bundle between the line-fetch arbiter and its surroundings:
// timing driver, pixel writer, framebuffer RAM and scan-out line buffer.
interface vga_line_fetch_arbiter_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17,
    parameter int LB_AW  = 8
);
    // Writer handshake: wr_req is held with stable wr_addr/wr_data until
    // wr_ack pulses for one cycle, which is the cycle the RAM write is issued.
    // wr_req is ignored while wr_ack=1, so back-to-back writes take 2 cycles.
    logic              line_req;
    logic [9:0]        line_num;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              lb_we;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb_wdata;
    logic              fill_busy;
    logic              fill_overrun;

    modport slave (
        input  line_req, line_num, wr_req, wr_addr, wr_data, ram_rdata,
        output wr_ack, ram_en, ram_we, ram_addr, ram_wdata,
               lb_we, lb_addr, lb_wdata, fill_busy, fill_overrun
    );

    modport master (
        output line_req, line_num, wr_req, wr_addr, wr_data, ram_rdata,
        input  wr_ack, ram_en, ram_we, ram_addr, ram_wdata,
               lb_we, lb_addr, lb_wdata, fill_busy, fill_overrun
    );
endinterface

// File: rtl/vga_line_fetch_arbiter.sv
// Single-port framebuffer arbiter: line prefetch bursts into the scan-out
// line buffer take priority; single-word pixel writes fill the idle gaps.
module vga_line_fetch_arbiter #(
    parameter int DATA_W         = 12,
    parameter int ADDR_W         = 17,
    parameter int WORDS_PER_LINE = 160,
    parameter int LB_AW          = 8
) (
    input  logic                     clk_vga,
    input  logic                     rst_n,
    vga_line_fetch_arbiter_if.slave  bus,
    output logic [1:0]               dbg_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LB_AW-1:0] LAST_IDX = LB_AW'(WORDS_PER_LINE - 1);

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [LB_AW-1:0]  idx;
    logic [LB_AW-1:0]  idx_next;
    logic [ADDR_W-1:0] line_base;

    assign idx_next  = idx + LB_AW'(1);
    // Product wraps modulo 2^ADDR_W by truncation.
    assign line_base = ADDR_W'(bus.line_num) * ADDR_W'(WORDS_PER_LINE);
    assign dbg_state = state;
    assign bus.lb_wdata = bus.lb_we ? bus.ram_rdata : '0;

    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            base             <= '0;
            idx              <= '0;
            bus.ram_en       <= 1'b0;
            bus.ram_we       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_wdata    <= '0;
            bus.wr_ack       <= 1'b0;
            bus.lb_we        <= 1'b0;
            bus.lb_addr      <= '0;
            bus.fill_busy    <= 1'b0;
            bus.fill_overrun <= 1'b0;
        end else begin
            // Line-buffer write trails each read issue by the RAM latency.
            bus.lb_we   <= (state == FILL);
            bus.lb_addr <= (state == FILL) ? idx : '0;
            bus.wr_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.line_req) begin
                        base          <= line_base;
                        idx           <= '0;
                        bus.ram_en    <= 1'b1;
                        bus.ram_we    <= 1'b0;
                        bus.ram_addr  <= line_base;
                        bus.fill_busy <= 1'b1;
                        state         <= FILL;
                    end else if (bus.wr_req && !bus.wr_ack) begin
                        bus.ram_en    <= 1'b1;
                        bus.ram_we    <= 1'b1;
                        bus.ram_addr  <= bus.wr_addr;
                        bus.ram_wdata <= bus.wr_data;
                        bus.wr_ack    <= 1'b1;
                    end else begin
                        bus.ram_en    <= 1'b0;
                        bus.ram_we    <= 1'b0;
                    end
                end
                FILL: begin
                    if (bus.line_req) bus.fill_overrun <= 1'b1;
                    if (idx == LAST_IDX) begin
                        bus.ram_en <= 1'b0;
                        state      <= DRAIN;
                    end else begin
                        idx          <= idx_next;
                        bus.ram_addr <= base + ADDR_W'(idx_next);
                    end
                end
                DRAIN: begin
                    if (bus.line_req) bus.fill_overrun <= 1'b1;
                    bus.fill_busy <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vga_line_fetch_arbiter.md
Name: vga_line_fetch_arbiter

Overview:
- Shares one single-port framebuffer RAM between two users: the VGA scan-out line prefetch (priority) and a pixel writer from the drawing logic (background).
- On each line request, bursts WORDS_PER_LINE words for the requested line from RAM into the scan-out line buffer.
- Between bursts, grants the RAM to single-word writer transactions using a req/ack handshake.
- Sits between the 640x480 timing driver (which produces the line request in blanking) and the framebuffer/line-buffer memories.

Parameters:
- DATA_W, 12, pixel word width (RGB444).
- ADDR_W, 17, framebuffer address width.
- WORDS_PER_LINE, 160, words fetched per line (must be >= 2).
- LB_AW, 8, line-buffer address width (2^LB_AW >= WORDS_PER_LINE).

Ports:
- clk_vga  in  1  pixel clock, 25 MHz; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_req  in  1  one-cycle pulse: fetch line line_num.
- line_num  in  10  framebuffer line index, sampled with line_req.
- wr_req  in  1  writer request, held until wr_ack.
- wr_addr  in  ADDR_W  writer address, stable while wr_req=1.
- wr_data  in  DATA_W  writer data, stable while wr_req=1.
- wr_ack  out  1  one-cycle pulse: write issued this cycle.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_en with ram_we=0.
- lb_we  out  1  line-buffer write strobe.
- lb_addr  out  LB_AW  line-buffer write address.
- lb_wdata  out  DATA_W  line-buffer write data (= ram_rdata).
- fill_busy  out  1  high from the first read issue until the last line-buffer write.
- fill_overrun  out  1  sticky error flag.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; index and base registers 0. A fill in progress is aborted, with no further lb_we.
- All ram_* outputs, wr_ack, fill_busy and fill_overrun are registered. lb_we and lb_addr are a one-cycle-delayed copy of the read issue.
- FSM states: IDLE, FILL, DRAIN.
- IDLE + line_req at cycle 0:
  - base <= line_num*WORDS_PER_LINE, truncated to ADDR_W; idx <= 0; go to FILL.
  - line_req has priority over a simultaneous wr_req, which waits.
- FILL, cycles 1..W (W = WORDS_PER_LINE):
  - ram_en=1, ram_we=0, ram_addr=base+idx, with idx running 0..W-1.
  - After issuing idx=W-1, go to DRAIN.
- Line-buffer writes:
  - lb_we=1 in cycles 2..W+1; lb_addr = idx of the previous cycle (0..W-1); lb_wdata = ram_rdata.
  - DRAIN is cycle W+1, with ram_en=0. Then return to IDLE; a new request can be accepted in cycle W+2.
- fill_busy = 1 in cycles 1..W+1 inclusive.
- Writer access:
  - In IDLE with wr_req=1, no line_req, and wr_ack=0 in the current cycle: next cycle ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1, each for exactly one cycle.
  - wr_req is not sampled in a cycle where wr_ack=1, so the maximum write rate is one per 2 cycles.
  - Writer requests arriving during FILL/DRAIN stall (wr_ack held 0) until IDLE.
- line_req while in FILL or DRAIN: the request is ignored and fill_overrun <= 1. The current fill continues unaffected. The flag clears only on reset.
- Address arithmetic is modulo 2^ADDR_W; base+idx wraps silently.
- ram_we is never 1 while fill_busy=1.

Test Plan:
1. Reset then line_req with line_num=3, W=160 → ram_addr 480..639 on cycles 1..160; lb_we on cycles 2..161 with lb_addr 0..159 and lb_wdata equal to RAM model contents; fill_busy high for 161 cycles.
2. IDLE, wr_req with wr_addr=0x00123, wr_data=0xABC → next cycle ram_we=1, ram_addr=0x00123, wr_ack=1 for one cycle; a held wr_req yields the next ack 2 cycles later.
3. line_req and wr_req in the same cycle → fill runs first; wr_ack arrives in cycle W+3, and RAM contents at the write address are written after the read burst.
4. line_req pulsed at cycle 50 of a fill → fill_overrun=1 and stays 1; burst addresses unchanged; no second burst.
5. rst_n asserted at cycle 80 of a fill → all outputs 0 immediately; after release, no lb_we until a new line_req.
6. line_num=1023, ADDR_W=17 → base = 163680 mod 131072 = 32608; addresses increment from 32608.
